// File: rtl/obb_reader_if.sv
// obb_reader_if: request, OBB field inputs and the valid/ready beat stream of obb_reader.
// master: the side that issues req, supplies the fields and consumes beats.
// slave: the reader itself.
interface obb_reader_if;
    logic               req;
    logic signed [31:0] pos_x;
    logic signed [31:0] pos_y;
    logic signed [31:0] vel_x;
    logic signed [31:0] vel_y;
    logic        [15:0] width;
    logic        [15:0] height;
    logic signed [31:0] angle;
    logic signed [31:0] omega;
    logic        [15:0] mass;
    logic signed [31:0] inv_mass;
    logic signed [31:0] inertia;
    logic signed [31:0] inv_inertia;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic        [31:0] out_data;
    logic        [3:0]  out_idx;
    logic               out_last;
    logic               done;

    modport master (
        output req, pos_x, pos_y, vel_x, vel_y, width, height, angle, omega, mass,
               inv_mass, inertia, inv_inertia, out_ready,
        input  busy, out_valid, out_data, out_idx, out_last, done
    );

    modport slave (
        input  req, pos_x, pos_y, vel_x, vel_y, width, height, angle, omega, mass,
               inv_mass, inertia, inv_inertia, out_ready,
        output busy, out_valid, out_data, out_idx, out_last, done
    );
endinterface

// File: rtl/obb_reader.sv
// obb_reader: on req, snapshots one OBB record and streams the fields enabled in FIELD_MASK
// as valid/ready beats in ascending field-index order, then pulses done.
// Optional build macro OBB_READER_CHECKSUM_EN appends a final beat (idx 4'hF) carrying the
// XOR of all data beats of the record.
module obb_reader #(
    parameter logic [11:0] FIELD_MASK = 12'hFFF
) (
    input logic         clk,
    input logic         reset,
    obb_reader_if.slave bus
);

`ifdef OBB_READER_CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StSend, StCsum} state_e;
`else
    typedef enum logic [0:0] {StIdle, StSend} state_e;
`endif

    localparam bit HasField = |FIELD_MASK;

    state_e            state_q, state_d;
    logic [11:0][31:0] snap_q;
    logic [3:0]        idx_q, idx_d;
    logic              done_q, done_d;
    logic              start;
    logic [3:0]        first_idx, next_idx;
    logic              has_next;
`ifdef OBB_READER_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    // Lowest enabled index overall, and lowest enabled index above the current beat.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        has_next  = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            if (FIELD_MASK[i]) begin
                first_idx = 4'(i);
                if (4'(i) > idx_q) begin
                    next_idx = 4'(i);
                    has_next = 1'b1;
                end
            end
        end
    end

    // Next-state logic: start on req in idle, advance on each accepted beat.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        start   = 1'b0;
`ifdef OBB_READER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.req) begin
                    start = 1'b1;
                    idx_d = first_idx;
`ifdef OBB_READER_CHECKSUM_EN
                    csum_d  = '0;
                    state_d = HasField ? StSend : StCsum;
`else
                    if (HasField) state_d = StSend;
                    else          done_d  = 1'b1;
`endif
                end
            end
            StSend: begin
                if (bus.out_ready) begin
`ifdef OBB_READER_CHECKSUM_EN
                    csum_d = csum_q ^ snap_q[idx_q];
`endif
                    if (has_next) begin
                        idx_d = next_idx;
                    end else begin
`ifdef OBB_READER_CHECKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef OBB_READER_CHECKSUM_EN
            StCsum: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State register; reset abandons any record without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            done_q  <= 1'b0;
`ifdef OBB_READER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
`ifdef OBB_READER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Snapshot of all twelve fields, 16-bit fields zero-extended, taken only at record start.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q <= '0;
        end else if (start) begin
            snap_q[0]  <= bus.pos_x;
            snap_q[1]  <= bus.pos_y;
            snap_q[2]  <= bus.vel_x;
            snap_q[3]  <= bus.vel_y;
            snap_q[4]  <= {16'h0000, bus.width};
            snap_q[5]  <= {16'h0000, bus.height};
            snap_q[6]  <= bus.angle;
            snap_q[7]  <= bus.omega;
            snap_q[8]  <= {16'h0000, bus.mass};
            snap_q[9]  <= bus.inv_mass;
            snap_q[10] <= bus.inertia;
            snap_q[11] <= bus.inv_inertia;
        end
    end

    // Beat outputs decoded from state; all zero while idle.
    always_comb begin
        bus.busy      = (state_q != StIdle);
        bus.out_valid = (state_q != StIdle);
        bus.done      = done_q;
        bus.out_idx   = '0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        case (state_q)
            StSend: begin
                bus.out_idx  = idx_q;
                bus.out_data = snap_q[idx_q];
`ifdef OBB_READER_CHECKSUM_EN
                bus.out_last = 1'b0;
`else
                bus.out_last = !has_next;
`endif
            end
`ifdef OBB_READER_CHECKSUM_EN
            StCsum: begin
                bus.out_idx  = 4'hF;
                bus.out_data = csum_q;
                bus.out_last = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_obb_reader.sv
// tb_obb_reader: directed bench for obb_reader. Four instances share stimulus and differ in
// FIELD_MASK (FFF, 021, 000, 003); a selector picks which one the current test observes.
module tb_obb_reader;

`ifdef OBB_READER_CHECKSUM_EN
    localparam bit CsumOn = 1'b1;
`else
    localparam bit CsumOn = 1'b0;
`endif
    localparam logic [47:0] Masks = 48'h003_000_021_FFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] fld [12];

    logic        mon_v    [4];
    logic        mon_busy [4];
    logic        mon_last [4];
    logic        mon_done [4];
    logic [31:0] mon_data [4];
    logic [3:0]  mon_idx  [4];

    int          sel = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [3:0]  exp_idx  [$];
    logic [31:0] exp_data [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        obb_reader_if bus ();
        assign bus.req         = req;
        assign bus.out_ready   = out_ready;
        assign bus.pos_x       = fld[0];
        assign bus.pos_y       = fld[1];
        assign bus.vel_x       = fld[2];
        assign bus.vel_y       = fld[3];
        assign bus.width       = fld[4][15:0];
        assign bus.height      = fld[5][15:0];
        assign bus.angle       = fld[6];
        assign bus.omega       = fld[7];
        assign bus.mass        = fld[8][15:0];
        assign bus.inv_mass    = fld[9];
        assign bus.inertia     = fld[10];
        assign bus.inv_inertia = fld[11];
        assign mon_v[g]        = bus.out_valid;
        assign mon_busy[g]     = bus.busy;
        assign mon_last[g]     = bus.out_last;
        assign mon_done[g]     = bus.done;
        assign mon_data[g]     = bus.out_data;
        assign mon_idx[g]      = bus.out_idx;

        obb_reader #(
            .FIELD_MASK (Masks[g*12 +: 12])
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Expected beat list for a mask, including the checksum beat when that build is in use.
    task automatic build_exp(input logic [11:0] mask);
        logic [31:0] x;
        x = '0;
        exp_idx.delete();
        exp_data.delete();
        for (int i = 0; i < 12; i++) begin
            if (mask[i]) begin
                exp_idx.push_back(4'(i));
                exp_data.push_back(fld[i]);
                x ^= fld[i];
            end
        end
        if (CsumOn) begin
            exp_idx.push_back(4'hF);
            exp_data.push_back(x);
        end
    endtask

    // Pulse req and walk the record against the expected list. bp applies the ready pattern
    // 1,0,0,1; mutate changes pos_x after the snapshot and issues a stray req while busy.
    task automatic run_record(input string tag, input bit bp, input bit mutate);
        int n, beat, cyc;
        bit rdy;
        n = exp_idx.size();
        beat = 0;
        cyc = 0;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        if (mutate) fld[0] = 32'h00300000;
        while (beat < n && cyc < 100) begin
            check_eq({tag, ".valid"}, 32'(mon_v[sel]), 32'd1);
            check_eq({tag, ".busy"}, 32'(mon_busy[sel]), 32'd1);
            check_eq({tag, ".done_early"}, 32'(mon_done[sel]), 32'd0);
            check_eq({tag, ".idx"}, 32'(mon_idx[sel]), 32'(exp_idx[beat]));
            check_eq({tag, ".data"}, mon_data[sel], exp_data[beat]);
            check_eq({tag, ".last"}, 32'(mon_last[sel]), 32'(beat == n - 1));
            rdy = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            out_ready = rdy;
            req = (mutate && beat == 2);
            @(negedge clk);
            if (rdy) beat++;
            cyc++;
        end
        req = 1'b0;
        out_ready = 1'b1;
        check_eq({tag, ".beats"}, 32'(beat), 32'(n));
        check_eq({tag, ".done"}, 32'(mon_done[sel]), 32'd1);
        check_eq({tag, ".valid_end"}, 32'(mon_v[sel]), 32'd0);
        check_eq({tag, ".busy_end"}, 32'(mon_busy[sel]), 32'd0);
        @(negedge clk);
        check_eq({tag, ".done_once"}, 32'(mon_done[sel]), 32'd0);
        check_eq({tag, ".no_restart"}, 32'(mon_v[sel]), 32'd0);
    endtask

    initial begin
        fld[0]  = 32'h00200000;
        fld[1]  = 32'h11111111;
        fld[2]  = 32'h22222222;
        fld[3]  = 32'h33333333;
        fld[4]  = 32'h0000000A;
        fld[5]  = 32'h00000014;
        fld[6]  = 32'h44444444;
        fld[7]  = 32'h55555555;
        fld[8]  = 32'h00000030;
        fld[9]  = 32'h66666666;
        fld[10] = 32'h77777777;
        fld[11] = 32'h88888888;

        // Reset state.
        do_reset();
        sel = 0;
        check_eq("rst.valid", 32'(mon_v[0]), 32'd0);
        check_eq("rst.busy", 32'(mon_busy[0]), 32'd0);
        check_eq("rst.done", 32'(mon_done[0]), 32'd0);
        check_eq("rst.last", 32'(mon_last[0]), 32'd0);
        check_eq("rst.data", mon_data[0], 32'd0);
        check_eq("rst.idx", 32'(mon_idx[0]), 32'd0);

        // Full record with snapshot isolation and a stray req while busy.
        build_exp(12'hFFF);
        run_record("full", 1'b0, 1'b1);

        // Backpressure on the full record.
        do_reset();
        fld[0] = 32'h00200000;
        build_exp(12'hFFF);
        run_record("bp", 1'b1, 1'b0);

        // Sparse mask: idx 0 then idx 5.
        do_reset();
        sel = 1;
        build_exp(12'h021);
        run_record("sparse", 1'b0, 1'b0);

        // Empty mask: done only (or a lone zero checksum beat).
        do_reset();
        sel = 2;
        build_exp(12'h000);
        run_record("zero", 1'b0, 1'b0);

        // Two-field record whose checksum is all ones.
        do_reset();
        sel = 3;
        fld[0] = 32'hF0F0F0F0;
        fld[1] = 32'h0F0F0F0F;
        build_exp(12'h003);
        run_record("csum", 1'b0, 1'b0);

        // Reset during beat 3, with req also high, then a clean restart from idx 0.
        do_reset();
        sel = 0;
        fld[0] = 32'h00200000;
        fld[1] = 32'h11111111;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid.idx3", 32'(mon_idx[0]), 32'd3);
        reset = 1'b1;
        req = 1'b1;
        @(negedge clk);
        check_eq("mid.valid", 32'(mon_v[0]), 32'd0);
        check_eq("mid.busy", 32'(mon_busy[0]), 32'd0);
        check_eq("mid.done", 32'(mon_done[0]), 32'd0);
        reset = 1'b0;
        req = 1'b0;
        @(negedge clk);
        check_eq("mid.no_done", 32'(mon_done[0]), 32'd0);
        check_eq("mid.idle", 32'(mon_v[0]), 32'd0);
        build_exp(12'hFFF);
        run_record("restart", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/obb_reader.md
OBB_READER -- requirements
Module: obb_reader

Interface
REQ-001 SHALL have parameter FIELD_MASK, default 12'hFFF; bit i enables streaming of field index i.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  1  request to snapshot and stream one OBB record.
REQ-005 SHALL have OBB input ports pos_x, pos_y, vel_x, vel_y, angle, omega, inv_mass, inertia, inv_inertia (each 32, signed fixed-point) and width, height, mass (each 16, unsigned).
REQ-006 SHALL have port busy  output  1  high from snapshot until the record completes.
REQ-007 SHALL have port out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the beat.
REQ-009 SHALL have port out_data  output  32  field value.
REQ-010 SHALL have port out_idx  output  4  field index of the current beat.
REQ-011 SHALL have port out_last  output  1  current beat is the final beat of the record.
REQ-012 SHALL have port done  output  1  single-cycle pulse when a record completes.

Function
REQ-013 Field index order SHALL be: 0 pos_x, 1 pos_y, 2 vel_x, 3 vel_y, 4 width, 5 height, 6 angle, 7 omega, 8 mass, 9 inv_mass, 10 inertia, 11 inv_inertia.
REQ-014 16-bit fields SHALL be zero-extended to 32 bits; 32-bit fields SHALL pass unchanged.
REQ-015 FSM SHALL have states IDLE, SEND, CSUM (CSUM present only per REQ-027).
REQ-016 In IDLE with req=1 and FIELD_MASK!=0, the block SHALL register all twelve inputs into a snapshot, enter SEND, and assert busy and out_valid in the next cycle.
REQ-017 req SHALL be ignored while busy=1; a held req SHALL start a new record only when back in IDLE.
REQ-018 Disabled fields SHALL be skipped with no idle beat; the next beat SHALL carry the next enabled index in ascending order.
REQ-019 A beat SHALL transfer when out_valid and out_ready are both 1; out_data, out_idx and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 out_valid SHALL stay high back-to-back across beats when out_ready stays high (one beat per cycle).
REQ-021 out_last SHALL be 1 only on the final beat of the record.
REQ-022 After the final transfer, the next cycle SHALL have state IDLE, busy=0, out_valid=0 and done=1 for exactly one cycle.
REQ-023 With FIELD_MASK==0 and the feature of REQ-027 absent, req in IDLE SHALL produce only done=1 the next cycle, with no beats and busy remaining 0.
REQ-024 Input changes after the snapshot SHALL NOT affect the streamed values.

Reset
REQ-025 reset=1 SHALL force in the next cycle: state IDLE, busy=0, out_valid=0, out_last=0, done=0, out_data=0, out_idx=0, snapshot cleared.
REQ-026 reset mid-record SHALL abandon the record without asserting done; reset SHALL take priority over req.

Configuration
REQ-027 With OBB_READER_CHECKSUM_EN defined, the block SHALL append one CSUM beat (out_idx=4'hF, out_data=XOR of all data beats emitted in the record, out_last=1), and the last field beat SHALL have out_last=0; with FIELD_MASK==0, CSUM SHALL be the only beat, with out_data=0.
REQ-028 Without OBB_READER_CHECKSUM_EN, the block SHALL contain no CSUM state and 4'hF SHALL never appear on out_idx.

Verification
REQ-029 Full record: FIELD_MASK=12'hFFF, out_ready=1, req pulse -> 12 consecutive beats, idx 0..11, width=10 shown as 32'h0000000A, out_last on idx 11, done the following cycle.
REQ-030 Backpressure: out_ready toggles 1,0,0,1 -> each beat is held stable during the 0 cycles, no beat is lost or duplicated, and the total is 12 beats.
REQ-031 Sparse mask: FIELD_MASK=12'h021 -> beats idx 0 then idx 5, out_last on idx 5.
REQ-032 Snapshot isolation: pos_x changes from 32'h00200000 to 32'h00300000 one cycle after req -> beat idx 0 carries 32'h00200000; a second req during busy is ignored.
REQ-033 Reset during beat 3 -> out_valid=0 and busy=0 the next cycle, no done pulse; a new req then restarts at idx 0.
REQ-034 Checksum build: mask 12'h003, pos_x=32'hF0F0F0F0, pos_y=32'h0F0F0F0F -> third beat has idx F, data 32'hFFFFFFFF and out_last=1.
